m2v_blkseq: RTL

M2V_BLKSEQ -- requirements
Module: m2vblkseq

---
 rtl/m2v_blkseq_if.sv | 31 +++
 rtl/m2v_blkseq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/m2v_blkseq_if.sv
// Handshake bundle between header parser, block sequencer, VLD and the IDCT/side-info pipeline.
// The sequencer takes the slave view; whoever feeds headers and consumes block pulses takes the master view.
interface m2v_blkseq_if;
  logic       mb_valid;
  logic [5:0] mb_pattern;
  logic       mb_intra;
  logic       pic_end;
  logic       blk_ready;
  logic       vld_done;
  logic       block_start;
  logic       vld_start;
  logic [2:0] cur_block;
  logic       mb_ready;
  logic       mb_done;
  logic       pic_done;
  logic       busy;
  logic       err_overrun;
  logic       err_timeout;

  modport slave (
    input  mb_valid, mb_pattern, mb_intra, pic_end, blk_ready, vld_done,
    output block_start, vld_start, cur_block, mb_ready, mb_done, pic_done,
           busy, err_overrun, err_timeout
  );

  modport master (
    output mb_valid, mb_pattern, mb_intra, pic_end, blk_ready, vld_done,
    input  block_start, vld_start, cur_block, mb_ready, mb_done, pic_done,
           busy, err_overrun, err_timeout
  );
endinterface

// File: rtl/m2v_blkseq.sv
// MPEG-2 block sequencer: walks the 6 blocks of a macroblock, launches VLD on coded ones, flushes at picture end.
// Header to first block_start 2 cycles; each block (and the flush) stalls in a wait state while blk_ready=0.
module m2v_blkseq #(
  parameter int TMO_WIDTH = 12
) (
  input logic         clk,
  input logic         reset,
  m2v_blkseq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ISSUE,
    DECODE,
    NEXT,
    FLUSH_WAIT,
    FLUSH
  } state_t;

  localparam logic [TMO_WIDTH-1:0] TMO_MAX  = '1;
  localparam logic [2:0]           LAST_BLK = 3'd5;

  state_t               state;
  state_t               state_nxt;
  logic [5:0]           pattern;
  logic [2:0]           blk_cnt;
  logic [TMO_WIDTH-1:0] wdog;
  logic                 pic_pend;
  logic                 err_overrun_q;
  logic                 err_timeout_q;
  logic                 mb_take;
  logic                 tmo_hit;

  // A header is taken in IDLE even if a flush is pending; the flush then follows the macroblock.
  assign mb_take = bus.mb_valid && (state == IDLE);
  // vld_done in the terminal-count cycle takes precedence over the timeout.
  assign tmo_hit = (state == DECODE) && !bus.vld_done && (wdog == TMO_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.mb_valid) begin
          state_nxt = WAIT;
        end else if (pic_pend) begin
          state_nxt = FLUSH_WAIT;
        end
      end
      WAIT: begin
        if (bus.blk_ready) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = pattern[5] ? DECODE : NEXT;
      end
      DECODE: begin
        if (bus.vld_done || tmo_hit) begin
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        state_nxt = (blk_cnt == LAST_BLK) ? IDLE : WAIT;
      end
      FLUSH_WAIT: begin
        if (bus.blk_ready) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= '0;
      blk_cnt <= '0;
    end else if (mb_take) begin
      pattern <= bus.mb_intra ? 6'b111111 : bus.mb_pattern;
      blk_cnt <= '0;
    end else begin
      if (state == ISSUE) begin
        pattern <= {pattern[4:0], 1'b0};
      end
      if ((state == NEXT) && (blk_cnt != LAST_BLK)) begin
        blk_cnt <= blk_cnt + 3'd1;
      end
    end
  end

  // Holding the counter at zero outside DECODE gives a clean start on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == DECODE) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end

  // A pic_end arriving in the FLUSH cycle belongs to the next picture and is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pic_pend <= 1'b0;
    end else if (state == FLUSH) begin
      pic_pend <= bus.pic_end;
    end else if (bus.pic_end) begin
      pic_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      if (bus.mb_valid && (state != IDLE)) begin
        err_overrun_q <= 1'b1;
      end
      if (tmo_hit) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.block_start = (state == ISSUE) || (state == FLUSH);
  assign bus.vld_start   = (state == ISSUE) && pattern[5];
  assign bus.cur_block   = blk_cnt;
  assign bus.mb_ready    = (state == IDLE) && !pic_pend && !bus.pic_end;
  assign bus.mb_done     = (state == NEXT) && (blk_cnt == LAST_BLK);
  assign bus.pic_done    = (state == FLUSH);
  assign bus.busy        = (state != IDLE);
  assign bus.err_overrun = err_overrun_q;
  assign bus.err_timeout = err_timeout_q;

  a_blk_range: assert property (@(posedge clk) disable iff (reset) blk_cnt <= LAST_BLK);
  a_vld_with_blk: assert property (@(posedge clk) disable iff (reset) bus.vld_start |-> bus.block_start);

endmodule
